// File: rtl/cnn_window_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cnn_window_ctrl_pkg
// Shared definitions for the 3x3 window sequencer.
// Provides:
//   - default frame geometry and datapath widths
//   - FSM state encoding
//   - tap offset helpers: tap k sits at dx = k%3-1, dy = k/3-1 (row-major)
// -----------------------------------------------------------------------------
package cnn_window_ctrl_pkg;

    localparam int IMG_W_DEF  = 480;
    localparam int IMG_H_DEF  = 272;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 24;
    localparam int RD_LAT_DEF = 1;
    localparam int NUM_TAPS   = 9;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Horizontal offset of tap k: -1, 0, +1
    function automatic logic signed [1:0] tap_dx(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: tap_dx = 2'sb11;
            4'd1, 4'd4, 4'd7: tap_dx = 2'sb00;
            default:          tap_dx = 2'sb01;
        endcase
    endfunction

    // Vertical offset of tap k: -1, 0, +1
    function automatic logic signed [1:0] tap_dy(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: tap_dy = 2'sb11;
            4'd3, 4'd4, 4'd5: tap_dy = 2'sb00;
            default:          tap_dy = 2'sb01;
        endcase
    endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// -----------------------------------------------------------------------------
// cnn_win_addr_gen
// Raster position counters plus tap address generation for the window scan.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   advance      step to the next raster position (wraps to (0,0) after the
//                last pixel of the frame)
//   tap          tap index 0..8 to evaluate
//   addr         memory address of that tap (valid when in_range)
//   in_range     tap lies inside the frame
//   last_pos     current position is the last pixel (IMG_W-1, IMG_H-1)
// -----------------------------------------------------------------------------
module cnn_win_addr_gen
    import cnn_window_ctrl_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic [3:0]        tap,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range,
    output logic              last_pos
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int SW = ADDR_W + 2;
    localparam logic [XW-1:0]        X_MAX   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]        Y_MAX   = YW'(IMG_H - 1);
    localparam logic signed [SW-1:0] ROW_OFF = SW'(IMG_W);

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [ADDR_W-1:0]    centre;
    logic signed [1:0]    dx, dy;
    logic signed [SW-1:0] off, sum;
    logic                 x_ok, y_ok;

    assign last_pos = (x == X_MAX) && (y == Y_MAX);

    // Centre address tracks y*IMG_W+x incrementally, so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            centre <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                if (y == Y_MAX) begin
                    y      <= '0;
                    centre <= '0;
                end else begin
                    y      <= y + YW'(1);
                    centre <= centre + ADDR_W'(1);
                end
            end else begin
                x      <= x + XW'(1);
                centre <= centre + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        dx  = tap_dx(tap);
        dy  = tap_dy(tap);
        off = {{(SW-2){dx[1]}}, dx};
        if (dy[1])
            off = off - ROW_OFF;
        else if (dy[0])
            off = off + ROW_OFF;
        sum  = $signed({2'b00, centre}) + off;
        addr = sum[ADDR_W-1:0];
        // Edge tests on x/y; the sum guard can only trip if the edge tests are wrong.
        x_ok = !(dx[1] && (x == '0)) && !(!dx[1] && dx[0] && (x == X_MAX));
        y_ok = !(dy[1] && (y == '0)) && !(!dy[1] && dy[0] && (y == Y_MAX));
        in_range = x_ok && y_ok && (sum[SW-1:ADDR_W] == '0);
    end

endmodule

// File: rtl/cnn_window_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_window_ctrl
// Scans an IMG_W x IMG_H frame in raster order and gathers one zero-padded
// 3x3 window per step from a single-port image memory.
// Ports:
//   iClk, iRst        clock, asynchronous active-low reset
//   iEn               step strobe (accepted only in WAIT with iBusy low)
//   iBusy             downstream backpressure, blocks starting a window
//   oRdEn, oAddr      memory read request
//   iRdData           read data, valid RD_LAT cycles after oRdEn
//   oOut0..oOut8      window taps, row-major, held between windows
//   oValid            one-cycle window-ready strobe
//   oFrameDone        pulse coincident with the last window's oValid
// Optional feature: define CNN_WIN_FRAME_LOOP_EN to restart the scan at (0,0)
// after the last window instead of parking in DONE until reset.
// -----------------------------------------------------------------------------
module cnn_window_ctrl
    import cnn_window_ctrl_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iBusy,
    output logic              oRdEn,
    output logic [ADDR_W-1:0] oAddr,
    input  logic [DATA_W-1:0] iRdData,
    output logic [DATA_W-1:0] oOut0,
    output logic [DATA_W-1:0] oOut1,
    output logic [DATA_W-1:0] oOut2,
    output logic [DATA_W-1:0] oOut3,
    output logic [DATA_W-1:0] oOut4,
    output logic [DATA_W-1:0] oOut5,
    output logic [DATA_W-1:0] oOut6,
    output logic [DATA_W-1:0] oOut7,
    output logic [DATA_W-1:0] oOut8,
    output logic              oValid,
    output logic              oFrameDone
);

    localparam logic [3:0] LAST_TAP   = 4'(NUM_TAPS - 1);
    localparam logic [3:0] LAST_DRAIN = 4'(RD_LAT - 1);

    state_t            state, state_next;
    logic [3:0]        k, k_next;
    logic              fetch_next;
    logic              advance;
    logic              tap_in_range;
    logic              last_pos;
    logic [ADDR_W-1:0] tap_addr;
    logic [DATA_W-1:0] shadow      [NUM_TAPS];
    logic [DATA_W-1:0] shadow_next [NUM_TAPS];
    logic [DATA_W-1:0] taps        [NUM_TAPS];
    logic              rp_vld      [RD_LAT];
    logic [3:0]        rp_idx      [RD_LAT];

    assign advance = (state == ST_OUT);

    // The address generator is driven with the tap index of the *next* cycle so
    // that oRdEn/oAddr can be registered without adding a cycle of latency.
    cnn_win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (iClk),
        .rst_n    (iRst),
        .advance  (advance),
        .tap      (k_next),
        .addr     (tap_addr),
        .in_range (tap_in_range),
        .last_pos (last_pos)
    );

    // k counts taps in FETCH and latency cycles in DRAIN.
    always_comb begin
        state_next = state;
        k_next     = k;
        case (state)
            ST_WAIT: begin
                if (iEn && !iBusy) begin
                    state_next = ST_FETCH;
                    k_next     = '0;
                end
            end
            ST_FETCH: begin
                if (k == LAST_TAP) begin
                    state_next = ST_DRAIN;
                    k_next     = '0;
                end else begin
                    k_next = k + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (k == LAST_DRAIN) begin
                    state_next = ST_OUT;
                    k_next     = '0;
                end else begin
                    k_next = k + 4'd1;
                end
            end
            ST_OUT: begin
`ifdef CNN_WIN_FRAME_LOOP_EN
                state_next = ST_WAIT;
`else
                state_next = last_pos ? ST_DONE : ST_WAIT;
`endif
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_WAIT;
        endcase
        fetch_next = (state_next == ST_FETCH);
    end

    // Shadow update: out-of-range taps are zeroed while fetching, returned
    // data lands in the tap tagged at the head of the return pipe. The merged
    // value feeds the taps directly so the final read is not missed.
    always_comb begin
        shadow_next = shadow;
        if ((state == ST_FETCH) && !oRdEn)
            shadow_next[k] = '0;
        if (rp_vld[RD_LAT-1])
            shadow_next[rp_idx[RD_LAT-1]] = iRdData;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= ST_WAIT;
            k          <= '0;
            oRdEn      <= 1'b0;
            oAddr      <= '0;
            oValid     <= 1'b0;
            oFrameDone <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= '0;
                taps[i]   <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                rp_vld[i] <= 1'b0;
                rp_idx[i] <= '0;
            end
        end else begin
            state      <= state_next;
            k          <= k_next;
            // Read request stage
            oRdEn      <= fetch_next && tap_in_range;
            oAddr      <= (fetch_next && tap_in_range) ? tap_addr : '0;
            // Read return stage: {valid, tap index} follows the memory latency
            rp_vld[0]  <= oRdEn;
            rp_idx[0]  <= k;
            for (int i = 1; i < RD_LAT; i++) begin
                rp_vld[i] <= rp_vld[i-1];
                rp_idx[i] <= rp_idx[i-1];
            end
            shadow     <= shadow_next;
            // Output stage: taps change only on entry to OUT
            oValid     <= (state_next == ST_OUT);
            oFrameDone <= (state_next == ST_OUT) && last_pos;
            if (state_next == ST_OUT)
                taps <= shadow_next;
        end
    end

    assign oOut0 = taps[0];
    assign oOut1 = taps[1];
    assign oOut2 = taps[2];
    assign oOut3 = taps[3];
    assign oOut4 = taps[4];
    assign oOut5 = taps[5];
    assign oOut6 = taps[6];
    assign oOut7 = taps[7];
    assign oOut8 = taps[8];

endmodule

// File: doc/cnn_window_ctrl.md
Name: cnn_window_ctrl

Overview:
Sequencer that scans a stored IMG_W x IMG_H RGB frame in raster order and gathers one 3x3 zero-padded window per step from the image memory. It issues nine single-port reads per window, collects the returned data, and presents the window as nine parallel taps with a one-cycle valid strobe for the convolution datapath. Stepping is gated by the periodic iEn strobe and the downstream iBusy backpressure.

Parameters:
IMG_W, 480, frame width in pixels
IMG_H, 272, frame height in pixels
ADDR_W, 17, image memory address width (IMG_W*IMG_H = 130560 words)
DATA_W, 24, pixel width (8b R,G,B)
RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
iClk  in  1  system clock
iRst  in  1  asynchronous active-low reset
iEn  in  1  step strobe, one cycle high
iBusy  in  1  downstream not ready; blocks start of a new window
oRdEn  out  1  memory read enable
oAddr  out  ADDR_W  memory read address
iRdData  in  DATA_W  read data, valid RD_LAT cycles after oRdEn
oOut0..oOut8  out  DATA_W each  window taps, row-major; tap k at dy=k/3-1, dx=k%3-1
oValid  out  1  one-cycle window-ready strobe
oFrameDone  out  1  one-cycle pulse coincident with the last window's oValid

Behaviour:
- Reset (async, iRst=0): state WAIT; position (x,y)=(0,0); oRdEn, oAddr, oOut0..8, oValid, oFrameDone and all shadow taps = 0.
- States:
  - WAIT: on iEn=1 and iBusy=0, go to FETCH with tap counter 0. iEn with iBusy=1 is dropped and the position is held. iEn in any other state is ignored.
  - FETCH: one tap per cycle, k=0..8.
    - In-range tap (0<=x+dx<IMG_W and 0<=y+dy<IMG_H): oRdEn=1, oAddr=(y+dy)*IMG_W+(x+dx).
    - Out-of-range tap: oRdEn=0, shadow tap k loads 0 that cycle.
    - After k=8, go to DRAIN.
  - DRAIN: RD_LAT cycles with oRdEn=0, then go to OUT.
  - OUT: copy shadow taps to oOut0..8 and assert oValid for one cycle.
    - If not the last window, advance x (wrap to 0 and y+1 at x=IMG_W-1) and go to WAIT.
    - Last window (IMG_W-1, IMG_H-1): also assert oFrameDone, then go to DONE.
  - DONE: no reads, no oValid. Behaviour depends on the optional feature.
- Read return path: a RD_LAT-deep shift register of {valid, tap index} steers iRdData into shadow tap k. oOut0..8 change only in the OUT cycle and hold between windows.
- Address arithmetic: keep a running centre address (y*IMG_W+x), incremented on each advance and reset to 0 at frame wrap. Tap address = centre + dy*IMG_W + dx, computed on ADDR_W+2 bits signed. No multiplier.
- Latency: oValid is high in cycle 10+RD_LAT after the edge that samples iEn (11 cycles at default). iEn period >= 16 keeps up.
- iBusy changing during FETCH/DRAIN/OUT has no effect; the window in flight completes.
- Reset mid-window: everything clears immediately and the scan restarts at (0,0).

Optional Feature:
Macro CNN_WIN_FRAME_LOOP_EN.
- Defined: OUT of the last window goes to WAIT with position (0,0) and centre address 0, so scanning repeats indefinitely. oFrameDone pulses once per frame.
- Undefined: the block parks in DONE until reset.

Decomposition:
- Shared package: IMG_W/IMG_H/ADDR_W/DATA_W defaults, the state encoding (WAIT, FETCH, DRAIN, OUT, DONE), and the tap dx/dy offset constants.
- One sub-module: cnn_win_addr_gen. It holds the x/y/centre counters and produces the tap address plus in-range flag for a given tap index. The FSM and tap capture stay in the top.

Test Plan:
- Reset, ROM word=address, one iEn -> reads only addresses 0,1,480,481. oOut0..3 and oOut6 = 0; oOut4=0, oOut5=1, oOut7=480, oOut8=481; oValid 11 cycles after iEn.
- Step to (1,1) (window index 481) -> reads 0,1,2,480,481,482,960,961,962 in tap order; oOut4=481.
- iBusy=1 across 100 iEn strobes -> no oRdEn, no oValid, position unchanged. First iEn after iBusy=0 yields the next raster window.
- Run the full frame -> exactly 130560 oValid. oFrameDone coincides with the last oValid, whose oOut4=130559, oOut5=oOut7=oOut8=0. With the macro undefined there are no further oRdEn; with it defined the next window has oOut5=1.
- Assert iRst low during FETCH tap 4 -> all outputs 0 the same instant. After release, the next window is (0,0) again.
- RD_LAT=3 build -> oValid 13 cycles after iEn; tap data correctly aligned.
